// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: 10b->8b decode, control token detect, word-alignment
// lock FSM with bitslip requests, and running-disparity error tracking.
// Ports: clk, n_rst (async, active-low); tmds_in[9:0] + in_valid from the
//   deserializer; pixel_data[7:0], ctrl[1:0], de, out_valid (1-clk latency);
//   locked (alignment state), bitslip and disp_err (one-cycle pulses).
module tmds_channel_decoder #(
   parameter int LOCK_COUNT = 8,
   parameter int TIMEOUT    = 4096,
   parameter int SETTLE     = 16,
   parameter int DISP_LIMIT = 16,
   parameter int ERR_LIMIT  = 4
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [9:0] tmds_in,
   input  logic       in_valid,
   output logic [7:0] pixel_data,
   output logic [1:0] ctrl,
   output logic       de,
   output logic       out_valid,
   output logic       locked,
   output logic       bitslip,
   output logic       disp_err
);
   localparam int LW = $clog2(LOCK_COUNT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(SETTLE + 1);
   localparam int EW = $clog2(ERR_LIMIT + 1);

   typedef enum logic [1:0] {
      S_SEARCH,
      S_SETTLE,
      S_LOCKED
   } state_t;

   state_t            state;
   logic [LW-1:0]     tok_cnt;
   logic [TW-1:0]     to_cnt;
   logic [SW-1:0]     set_cnt;
   logic [EW-1:0]     err_cnt;
   logic signed [6:0] rd;

   logic              is_tok;
   logic [1:0]        tok_code;
   logic [7:0]        d;
   logic [7:0]        dec;
   logic [3:0]        ones;
   logic signed [7:0] rd_sum;
   logic signed [6:0] rd_sat;
   logic              over;
   logic [LW-1:0]     tok_nxt;
   logic [TW-1:0]     to_nxt;
   logic [EW-1:0]     err_nxt;
   logic              err_hit;
   logic              to_hit;

   always_comb begin
      is_tok   = 1'b1;
      tok_code = 2'b00;
      unique case (tmds_in)
         10'h354: tok_code = 2'b00;
         10'h0AB: tok_code = 2'b01;
         10'h154: tok_code = 2'b10;
         10'h2AB: tok_code = 2'b11;
         default: is_tok   = 1'b0;
      endcase
   end

   // Undo the optional inversion, then the XOR/XNOR chain.
   always_comb begin
      d      = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0];
      dec    = '0;
      dec[0] = d[0];
      for (int i = 1; i < 8; i++)
         dec[i] = tmds_in[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
   end

   // Word disparity is 2*ones - 10; rd saturates at +/-63.
   always_comb begin
      ones = '0;
      for (int i = 0; i < 10; i++)
         ones = ones + 4'(tmds_in[i]);
      rd_sum = $signed({rd[6], rd})
             + $signed({3'b000, ones, 1'b0})
             - 8'sd10;
      if (rd_sum > 8'sd63)
         rd_sat = 7'sd63;
      else if (rd_sum < -8'sd63)
         rd_sat = -7'sd63;
      else
         rd_sat = rd_sum[6:0];
      over = (int'(rd_sat) > DISP_LIMIT) ||
             (int'(rd_sat) < -DISP_LIMIT);
   end

   always_comb begin
      tok_nxt = (tok_cnt == LW'(LOCK_COUNT)) ? tok_cnt : tok_cnt + 1'b1;
      to_nxt  = (to_cnt == TW'(TIMEOUT)) ? to_cnt : to_cnt + 1'b1;
      err_nxt = (err_cnt == EW'(ERR_LIMIT)) ? err_cnt : err_cnt + 1'b1;
      to_hit  = (to_nxt == TW'(TIMEOUT));
      err_hit = over && (err_nxt == EW'(ERR_LIMIT));
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= S_SEARCH;
         tok_cnt    <= '0;
         to_cnt     <= '0;
         set_cnt    <= '0;
         err_cnt    <= '0;
         rd         <= '0;
         pixel_data <= '0;
         ctrl       <= '0;
         de         <= 1'b0;
         out_valid  <= 1'b0;
         locked     <= 1'b0;
         bitslip    <= 1'b0;
         disp_err   <= 1'b0;
      end else begin
         out_valid <= in_valid;
         bitslip   <= 1'b0;
         disp_err  <= 1'b0;

         // Settle window runs on clk, independent of in_valid.
         if (state == S_SETTLE) begin
            tok_cnt <= '0;
            to_cnt  <= '0;
            if (set_cnt == SW'(SETTLE - 1)) begin
               set_cnt <= '0;
               state   <= S_SEARCH;
            end else begin
               set_cnt <= set_cnt + 1'b1;
            end
         end

         if (in_valid) begin
            if (is_tok) begin
               de   <= 1'b0;
               ctrl <= tok_code;
               rd   <= '0;
            end else begin
               pixel_data <= dec;
               de         <= (state == S_LOCKED);
               rd         <= over ? 7'sd0 : rd_sat;
               disp_err   <= over && (state == S_LOCKED);
            end

            unique case (state)
               S_SEARCH: begin
                  if (is_tok) begin
                     to_cnt <= '0;
                     if (tok_nxt == LW'(LOCK_COUNT)) begin
                        tok_cnt <= '0;
                        state   <= S_LOCKED;
                        locked  <= 1'b1;
                     end else begin
                        tok_cnt <= tok_nxt;
                     end
                  end else begin
                     tok_cnt <= '0;
                     if (to_hit) begin
                        to_cnt  <= '0;
                        set_cnt <= '0;
                        bitslip <= 1'b1;
                        state   <= S_SETTLE;
                     end else begin
                        to_cnt <= to_nxt;
                     end
                  end
               end
               S_LOCKED: begin
                  if (is_tok) begin
                     to_cnt  <= '0;
                     err_cnt <= '0;
                  end else if (err_hit || to_hit) begin
                     to_cnt  <= '0;
                     err_cnt <= '0;
                     tok_cnt <= '0;
                     locked  <= 1'b0;
                     state   <= S_SEARCH;
                  end else begin
                     to_cnt <= to_nxt;
                     if (over)
                        err_cnt <= err_nxt;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed self-checking bench for tmds_channel_decoder.
// Inputs change 1ns after posedge; outputs are checked at that same point.
module tb_tmds_channel_decoder;
   logic       clk;
   logic       n_rst;
   logic [9:0] tmds_in;
   logic       in_valid;
   logic [7:0] pixel_data;
   logic [1:0] ctrl;
   logic       de;
   logic       out_valid;
   logic       locked;
   logic       bitslip;
   logic       disp_err;

   int checks = 0;
   int errors = 0;

   tmds_channel_decoder dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .tmds_in    (tmds_in),
      .in_valid   (in_valid),
      .pixel_data (pixel_data),
      .ctrl       (ctrl),
      .de         (de),
      .out_valid  (out_valid),
      .locked     (locked),
      .bitslip    (bitslip),
      .disp_err   (disp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic [9:0] w, input logic v);
      tmds_in  = w;
      in_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      n_rst    = 1'b0;
      in_valid = 1'b0;
      tmds_in  = '0;
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
   endtask

   task automatic test_reset();
      n_rst    = 1'b0;
      in_valid = 1'b0;
      tmds_in  = 10'h354;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({pixel_data, ctrl, de, out_valid, locked, bitslip, disp_err}
          !== 15'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h exp 0",
                  {pixel_data, ctrl, de, out_valid, locked, bitslip, disp_err});
      end
      n_rst = 1'b1;
   endtask

   task automatic test_lock();
      for (int i = 0; i < 8; i++) begin
         step(10'h354, 1'b1);
         checks++;
         if ({out_valid, de, ctrl} !== 4'b1000) begin
            errors++;
            $display("FAIL lock_tok%0d got %b exp 1000", i, {out_valid, de, ctrl});
         end
         checks++;
         if (locked !== (i == 7)) begin
            errors++;
            $display("FAIL lock_state%0d got %b exp %b", i, locked, (i == 7));
         end
      end
   endtask

   task automatic test_ctrl_tokens();
      logic [9:0] w [3] = '{10'h2AB, 10'h0AB, 10'h154};
      logic [1:0] c [3] = '{2'b11, 2'b01, 2'b10};
      for (int i = 0; i < 3; i++) begin
         step(w[i], 1'b1);
         checks++;
         if ({ctrl, de, pixel_data, locked} !== {c[i], 1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL ctrl_tok%0d got %b/%b/%h exp %b/0/00",
                     i, ctrl, de, pixel_data, c[i]);
         end
      end
   endtask

   task automatic test_data();
      logic [9:0] w [5] = '{10'h100, 10'h0FF, 10'h133, 10'h163, 10'h37F};
      logic [7:0] p [5] = '{8'h00, 8'hFF, 8'h55, 8'hA5, 8'h80};
      for (int i = 0; i < 5; i++) begin
         step(w[i], 1'b1);
         checks++;
         if ({pixel_data, de, disp_err, ctrl} !== {p[i], 1'b1, 1'b0, 2'b10}) begin
            errors++;
            $display("FAIL data%0d got %h de=%b err=%b ctrl=%b exp %h de=1 err=0 ctrl=10",
                     i, pixel_data, de, disp_err, ctrl, p[i]);
         end
      end
   endtask

   task automatic test_disp_errors();
      step(10'h354, 1'b1);
      checks++;
      if ({ctrl, de} !== 3'b000) begin
         errors++;
         $display("FAIL disp_pre_tok got %b exp 000", {ctrl, de});
      end
      for (int i = 0; i < 8; i++) begin
         step(10'h3FF, 1'b1);
         checks++;
         if ({de, disp_err, locked, bitslip, pixel_data}
             !== {1'b1, (i % 2 == 1), (i < 7), 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL disp_word%0d got de=%b err=%b lk=%b slip=%b px=%h exp 1/%b/%b/0/00",
                     i, de, disp_err, locked, bitslip, pixel_data,
                     (i % 2 == 1), (i < 7));
         end
      end
      for (int i = 0; i < 2; i++) begin
         step(10'h3FF, 1'b1);
         checks++;
         if ({de, disp_err, locked} !== 3'b000) begin
            errors++;
            $display("FAIL disp_unlocked%0d got %b exp 000", i, {de, disp_err, locked});
         end
      end
   endtask

   task automatic test_bitslip();
      int nslip = 0;
      int slip_at = -1;
      do_reset();
      for (int i = 0; i < 4096; i++) begin
         step(10'h2A9, 1'b1);
         if (bitslip === 1'b1) begin
            nslip++;
            if (slip_at < 0) slip_at = i;
         end
      end
      checks++;
      if (slip_at !== 4095) begin
         errors++;
         $display("FAIL slip_index got %0d exp 4095", slip_at);
      end
      checks++;
      if ({de, locked, pixel_data} !== {1'b0, 1'b0, 8'h04}) begin
         errors++;
         $display("FAIL slip_search_out got de=%b lk=%b px=%h exp 0/0/04",
                  de, locked, pixel_data);
      end
      for (int i = 0; i < 16; i++) begin
         step(10'h2AB, 1'b1);
         if (bitslip === 1'b1) nslip++;
      end
      checks++;
      if (nslip !== 1) begin
         errors++;
         $display("FAIL slip_count got %0d exp 1", nslip);
      end
      checks++;
      if ({ctrl, de, locked} !== 4'b1100) begin
         errors++;
         $display("FAIL settle_ctrl got %b exp 1100", {ctrl, de, locked});
      end
      for (int i = 0; i < 8; i++) begin
         step(10'h354, 1'b1);
         checks++;
         if (locked !== (i == 7)) begin
            errors++;
            $display("FAIL relock%0d got %b exp %b", i, locked, (i == 7));
         end
      end
   endtask

   task automatic test_reset_slip();
      do_reset();
      for (int i = 0; i < 4096; i++)
         step(10'h2A9, 1'b1);
      checks++;
      if (bitslip !== 1'b1) begin
         errors++;
         $display("FAIL rst_slip_pre got %b exp 1", bitslip);
      end
      n_rst = 1'b0;
      #1;
      checks++;
      if ({bitslip, out_valid, locked} !== 3'b000) begin
         errors++;
         $display("FAIL rst_slip_drop got %b exp 000", {bitslip, out_valid, locked});
      end
      n_rst = 1'b1;
   endtask

   task automatic test_valid_gap();
      do_reset();
      for (int i = 0; i < 3; i++)
         step(10'h0AB, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(10'h3FF, 1'b0);
         checks++;
         if ({out_valid, ctrl, de, pixel_data} !== {1'b0, 2'b01, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL gap%0d got ov=%b ctrl=%b de=%b px=%h exp 0/01/0/00",
                     i, out_valid, ctrl, de, pixel_data);
         end
      end
      for (int i = 0; i < 5; i++) begin
         step(10'h0AB, 1'b1);
         checks++;
         if ({out_valid, locked} !== {1'b1, (i == 4)}) begin
            errors++;
            $display("FAIL gap_lock%0d got %b exp %b", i, {out_valid, locked},
                     {1'b1, (i == 4)});
         end
      end
      do_reset();
      step(10'h2AB, 1'b1);
      step(10'h2AB, 1'b1);
      checks++;
      if ({ctrl, out_valid} !== 3'b111) begin
         errors++;
         $display("FAIL mid_search_pre got %b exp 111", {ctrl, out_valid});
      end
      n_rst = 1'b0;
      #1;
      checks++;
      if ({pixel_data, ctrl, de, out_valid, locked, bitslip, disp_err}
          !== 15'd0) begin
         errors++;
         $display("FAIL mid_search_rst got %h exp 0",
                  {pixel_data, ctrl, de, out_valid, locked, bitslip, disp_err});
      end
      n_rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_lock();
      test_ctrl_tokens();
      test_data();
      test_disp_errors();
      test_bitslip();
      test_reset_slip();
      test_valid_gap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
